// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter.
// Holds the regfile port widths, the write-enable levels and the default
// requester/FIFO sizing, plus the {addr, data} entry type stored per FIFO slot.
package wb_arbiter_pkg;

  localparam int REG_NUM_LOG2 = 5;
  localparam int DATA_W       = 32;
  localparam int WB_REQ_NUM   = 3;
  localparam int WB_DEPTH     = 2;

  localparam logic              WRITE_ENABLE  = 1'b1;
  localparam logic              WRITE_DISABLE = 1'b0;
  localparam logic [DATA_W-1:0] ZERO_WORD     = '0;

  typedef struct packed {
    logic [REG_NUM_LOG2-1:0] addr;
    logic [DATA_W-1:0]       data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // Register x0 is hardwired to zero, so its entries never raise the write enable.
  function automatic logic write_en_for(input logic [REG_NUM_LOG2-1:0] addr);
    return (addr != '0) ? WRITE_ENABLE : WRITE_DISABLE;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus between the execution units, the write-back arbiter and the regfile port.
//   req_valid/req_waddr/req_wdata : per-requester result offer (slice i)
//   req_ready                     : per-requester FIFO has room
//   we/waddr/wdata                : registered regfile write port
//   idle                          : no buffered results and no write in flight
// master = execution-unit / regfile side, slave = arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_REQ_NUM
);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*REG_NUM_LOG2-1:0] req_waddr;
  logic [NUM_REQ*DATA_W-1:0]       req_wdata;
  logic                            we;
  logic [REG_NUM_LOG2-1:0]         waddr;
  logic [DATA_W-1:0]               wdata;
  logic                            idle;

  modport master (
    output req_valid, req_waddr, req_wdata,
    input  req_ready, we, waddr, wdata, idle
  );

  modport slave (
    input  req_valid, req_waddr, req_wdata,
    output req_ready, we, waddr, wdata, idle
  );

endinterface

// File: rtl/wb_fifo.sv
// Small per-requester result FIFO for the write-back arbiter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write one entry (caller guarantees !o_full)
//   i_pop          : drop the head entry (caller guarantees !o_empty)
//   o_data         : head entry, valid whenever !o_empty
//   o_full/o_empty : occupancy flags
// Storage is not reset; only pointers and count are, which discards contents.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (i_push && !i_pop)      r_cnt <= r_cnt + CW'(1);
      else if (i_pop && !i_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single regfile write port.
//   clk_in : clock, all state on the rising edge
//   rst_in : asynchronous active-low reset
//   bus    : wb_arbiter_if.slave (requester offers, ready, regfile write, idle)
// Each requester feeds its own wb_fifo; one non-empty FIFO is popped per
// cycle in round-robin order starting at r_rr_ptr, and the popped entry is
// registered onto we/waddr/wdata.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_REQ_NUM,
  parameter int DEPTH   = WB_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  wb_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      w_full;
  logic [NUM_REQ-1:0]      w_empty;
  logic [NUM_REQ-1:0]      w_push;
  logic [NUM_REQ-1:0]      w_pop;
  logic [NUM_REQ-1:0]      w_ready;
  wb_entry_t               w_head [NUM_REQ];
  logic                    w_grant_vld;
  logic [PTR_W-1:0]        w_grant_idx;
  int                      w_best_dist;

  logic [PTR_W-1:0]        r_rr_ptr;
  logic                    r_run;
  logic                    r_we;
  logic [REG_NUM_LOG2-1:0] r_waddr;
  logic [DATA_W-1:0]       r_wdata;

  // r_run holds ready/idle low until the first edge after reset release.
  assign w_ready = {NUM_REQ{r_run}} & ~w_full;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    wb_entry_t w_in;

    assign w_in.addr   = bus.req_waddr[gi*REG_NUM_LOG2 +: REG_NUM_LOG2];
    assign w_in.data   = bus.req_wdata[gi*DATA_W +: DATA_W];
    assign w_push[gi]  = bus.req_valid[gi] & w_ready[gi];
    assign w_pop[gi]   = w_grant_vld && (w_grant_idx == PTR_W'(gi));

    wb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .i_clk   (clk_in),
      .i_rst_n (rst_in),
      .i_push  (w_push[gi]),
      .i_pop   (w_pop[gi]),
      .i_data  (w_in),
      .o_data  (w_head[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi])
    );
  end

  // Rotating priority: the non-empty FIFO with the smallest forward distance
  // from r_rr_ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_empty[i] && (((i - int'(r_rr_ptr) + NUM_REQ) % NUM_REQ) < w_best_dist)) begin
        w_best_dist = (i - int'(r_rr_ptr) + NUM_REQ) % NUM_REQ;
        w_grant_idx = PTR_W'(i);
        w_grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_run    <= 1'b0;
      r_rr_ptr <= '0;
      r_we     <= WRITE_DISABLE;
      r_waddr  <= '0;
      r_wdata  <= ZERO_WORD;
    end else begin
      r_run <= 1'b1;
      if (w_grant_vld) begin
        r_we     <= write_en_for(w_head[w_grant_idx].addr);
        r_waddr  <= w_head[w_grant_idx].addr;
        r_wdata  <= w_head[w_grant_idx].data;
        r_rr_ptr <= (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);
      end else begin
        r_we <= WRITE_DISABLE;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.we        = r_we;
  assign bus.waddr     = r_waddr;
  assign bus.wdata     = r_wdata;
  assign bus.idle      = r_run & (&w_empty) & ~r_we;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N = 3;
  localparam int D = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_REQ(N)) bus ();

  wb_arbiter #(.NUM_REQ(N), .DEPTH(D)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per requester plus a round-robin start index.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q [N][$];
  int          m_rr;
  logic        m_run;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  typedef struct {
    logic [2:0]  v;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [2:0]  exp_ready;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_q[i].delete();
    m_rr    = 0;
    m_run   = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic model_step(input logic [2:0] v, input logic [14:0] a,
                            input logic [95:0] d, input logic [2:0] rdy);
    int   g;
    int   idx;
    ent_t e;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (g < 0 && m_q[idx].size() > 0) g = idx;
    end
    if (g >= 0) begin
      e       = m_q[g].pop_front();
      m_we    = (e.a != 5'd0);
      m_waddr = e.a;
      m_wdata = e.d;
      m_rr    = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i] && rdy[i]) begin
        e.a = a[i*5 +: 5];
        e.d = d[i*32 +: 32];
        m_q[i].push_back(e);
      end
    end
    m_run = 1'b1;
  endtask

  function automatic logic model_empty();
    for (int i = 0; i < N; i++) if (m_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  // Starts and ends at a falling edge; drives one cycle of offers and
  // checks ready before the edge and the write port after it.
  task automatic cycle(input logic [2:0] v, input logic [14:0] a,
                       input logic [95:0] d, output logic [2:0] acc);
    logic [2:0] exp_rdy;
    bus.req_valid = v;
    bus.req_waddr = a;
    bus.req_wdata = d;
    for (int i = 0; i < N; i++) exp_rdy[i] = m_run && (m_q[i].size() < D);
    #1;
    chk("ready", {29'd0, bus.req_ready}, {29'd0, exp_rdy});
    acc = v & exp_rdy;
    @(posedge clk);
    model_step(v, a, d, exp_rdy);
    @(negedge clk);
    chk("we",    {31'd0, bus.we},    {31'd0, m_we});
    chk("waddr", {27'd0, bus.waddr}, {27'd0, m_waddr});
    chk("wdata", bus.wdata, m_wdata);
    chk("idle",  {31'd0, bus.idle},  {31'd0, m_run && model_empty() && !m_we});
  endtask

  task automatic idle_cycle();
    logic [2:0] acc;
    cycle(3'b000, 15'd0, 96'd0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_we",    {31'd0, bus.we},        32'd0);
    chk("rst_waddr", {27'd0, bus.waddr},     32'd0);
    chk("rst_wdata", bus.wdata,              32'd0);
    chk("rst_ready", {29'd0, bus.req_ready}, 32'd0);
    chk("rst_idle",  {31'd0, bus.idle},      32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    chk("post_rst_ready", {29'd0, bus.req_ready}, 32'd7);
    chk("post_rst_idle",  {31'd0, bus.idle},      32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  acc;
    logic [14:0] a;
    logic [95:0] d;
    logic [4:0]  sa [N];
    logic [31:0] sd [N];
    logic [2:0]  v;

    tbl[0] = '{3'b111, 1'b0, 5'd0,  32'h0000_0000, 3'b111};
    tbl[1] = '{3'b111, 1'b1, 5'd1,  32'hA000_0000, 3'b001};
    tbl[2] = '{3'b111, 1'b1, 5'd9,  32'hA000_0100, 3'b010};
    tbl[3] = '{3'b111, 1'b1, 5'd17, 32'hA000_0200, 3'b100};
    tbl[4] = '{3'b111, 1'b1, 5'd2,  32'hA000_0001, 3'b001};
    tbl[5] = '{3'b111, 1'b1, 5'd10, 32'hA000_0101, 3'b010};
    tbl[6] = '{3'b111, 1'b1, 5'd18, 32'hA000_0201, 3'b100};
    tbl[7] = '{3'b111, 1'b1, 5'd3,  32'hA000_0002, 3'b001};

    bus.req_valid = '0;
    bus.req_waddr = '0;
    bus.req_wdata = '0;
    model_clear();

    // All three requesters offering every cycle; req i at row k offers
    // addr 1+8i+k, data A000_0000 | i<<8 | k.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i*5 +: 5]   = 5'(1 + i*8 + k);
        d[i*32 +: 32] = 32'hA000_0000 | (32'(i) << 8) | 32'(k);
      end
      cycle(tbl[k].v, a, d, acc);
      chk($sformatf("tbl%0d_we", k),    {31'd0, bus.we},        {31'd0, tbl[k].exp_we});
      chk($sformatf("tbl%0d_waddr", k), {27'd0, bus.waddr},     {27'd0, tbl[k].exp_waddr});
      chk($sformatf("tbl%0d_wdata", k), bus.wdata,              tbl[k].exp_wdata);
      chk($sformatf("tbl%0d_ready", k), {29'd0, bus.req_ready}, {29'd0, tbl[k].exp_ready});
    end

    // Single push on req 1: write visible for exactly one cycle, two edges later.
    do_reset();
    a = '0; d = '0;
    a[5 +: 5] = 5'd5; d[32 +: 32] = 32'hDEAD_BEEF;
    cycle(3'b010, a, d, acc);
    chk("single_t1_we", {31'd0, bus.we}, 32'd0);
    idle_cycle();
    chk("single_t2_we",    {31'd0, bus.we},   32'd1);
    chk("single_t2_waddr", {27'd0, bus.waddr}, 32'd5);
    chk("single_t2_wdata", bus.wdata,         32'hDEAD_BEEF);
    idle_cycle();
    chk("single_t3_we",   {31'd0, bus.we},   32'd0);
    chk("single_t3_idle", {31'd0, bus.idle}, 32'd1);

    // rr pointer now at 2: simultaneous req 1 / req 2 -> req 2 first.
    a = '0; d = '0;
    a[5 +: 5]  = 5'd6; d[32 +: 32] = 32'h61;
    a[10 +: 5] = 5'd7; d[64 +: 32] = 32'h72;
    cycle(3'b110, a, d, acc);
    idle_cycle();
    chk("rr2_first_waddr",  {27'd0, bus.waddr}, 32'd7);
    idle_cycle();
    chk("rr2_second_waddr", {27'd0, bus.waddr}, 32'd6);
    idle_cycle();

    // x0 entry consumes its slot without a write.
    do_reset();
    a = '0; d = '0;
    d[0 +: 32] = 32'h1234;
    cycle(3'b001, a, d, acc);
    a[0 +: 5] = 5'd3; d[0 +: 32] = 32'h55;
    cycle(3'b001, a, d, acc);
    chk("x0_we", {31'd0, bus.we}, 32'd0);
    idle_cycle();
    chk("x3_we",    {31'd0, bus.we},   32'd1);
    chk("x3_waddr", {27'd0, bus.waddr}, 32'd3);
    chk("x3_wdata", bus.wdata,         32'h55);
    idle_cycle();

    // Mid-stream reset with FIFOs occupied and rr pointer at 2.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i*5 +: 5]   = 5'(20 + i*3 + k);
        d[i*32 +: 32] = 32'hC0DE_0000 | 32'(i*16 + k);
      end
      cycle(3'b111, a, d, acc);
    end
    do_reset();
    idle_cycle();
    chk("after_rst_no_we", {31'd0, bus.we}, 32'd0);
    a = '0; d = '0;
    a[5 +: 5]  = 5'd11; d[32 +: 32] = 32'h1111;
    a[10 +: 5] = 5'd22; d[64 +: 32] = 32'h2222;
    cycle(3'b110, a, d, acc);
    idle_cycle();
    chk("rr0_first_waddr",  {27'd0, bus.waddr}, 32'd11);
    idle_cycle();
    chk("rr0_second_waddr", {27'd0, bus.waddr}, 32'd22);
    idle_cycle();

    // Random traffic; each source holds its offer until accepted.
    for (int i = 0; i < N; i++) begin
      sa[i] = 5'($urandom_range(0, 31));
      sd[i] = $urandom;
    end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i]          = (i == 2) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 65);
        a[i*5 +: 5]   = sa[i];
        d[i*32 +: 32] = sd[i];
      end
      cycle(v, a, d, acc);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          sa[i] = 5'($urandom_range(0, 31));
          sd[i] = $urandom;
        end
      end
    end
    for (int c = 0; c < 8; c++) idle_cycle();
    chk("drain_idle", {31'd0, bus.idle}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
